// File: rtl/multi_cycle_core_if.sv
// Unified instruction/data memory port: req/ack handshake, request fields held stable until ack.
// Master is the core; slave is the memory, which may acknowledge in the same cycle as the request.
interface multi_cycle_core_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/multi_cycle_core.sv
// Multi-cycle 16-bit MIPS-style core sharing one ALU and one memory port; branch 3, ALU 4, sw 4, lw 5 cycles.
// Each memory wait cycle adds one cycle; an optional timeout turns an unanswered request into ERROR.
module multi_cycle_core #(
    parameter logic [15:0] RESET_PC       = 16'h0000,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    multi_cycle_core_if.master   mem,
    output logic [15:0]          pc,
    output logic                 halted,
    output logic                 error,
    output logic [CNT_W-1:0]     instr_retired,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERROR  = 3'd6
    } state_e;

    localparam logic [2:0] OP_R    = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_LW   = 3'd2;
    localparam logic [2:0] OP_SW   = 3'd3;
    localparam logic [2:0] OP_BEQ  = 3'd4;
    localparam logic [2:0] OP_J    = 3'd5;
    localparam logic [2:0] OP_JAL  = 3'd6;
    localparam logic [2:0] OP_HLT  = 3'd7;
    localparam logic [3:0] FN_JR   = 4'd6;

    state_e             state_q, state_d;
    logic [15:0]        pc_q, pc_d;
    logic [15:0]        ir_q, ir_d;
    logic [15:0]        a_q, a_d;
    logic [15:0]        b_q, b_d;
    logic [15:0]        res_q, res_d;
    logic [15:0]        rf_q [8];
    logic [15:0]        rf_d [8];
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic [31:0]        tmo_q, tmo_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [15:0]        addr_q, addr_d;
    logic [15:0]        wdata_q, wdata_d;

    logic [2:0]  op, rs, rt, rd, dest;
    logic [3:0]  funct;
    logic [15:0] sext, pc2, alu_res;
    logic        hs, tmo_hit, retire;

    assign op    = ir_q[15:13];
    assign rs    = ir_q[12:10];
    assign rt    = ir_q[9:7];
    assign rd    = ir_q[6:4];
    assign funct = ir_q[3:0];
    assign sext  = {{9{ir_q[6]}}, ir_q[6:0]};
    assign pc2   = pc_q + 16'd2;
    assign dest  = (op == OP_R) ? rd : rt;

    // An ack only counts while our own request is up; stray acks are dropped here.
    assign hs      = req_q && mem.mem_ack;
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && req_q && !mem.mem_ack
                     && ((tmo_q + 32'd1) == TIMEOUT_CYCLES);

    always_comb begin
        alu_res = a_q + sext;
        if (op == OP_R) begin
            case (funct)
                4'd0:    alu_res = a_q + b_q;
                4'd1:    alu_res = a_q - b_q;
                4'd2:    alu_res = a_q & b_q;
                4'd3:    alu_res = a_q | b_q;
                4'd4:    alu_res = ($signed(a_q) < $signed(b_q)) ? 16'd1 : 16'd0;
                4'd5:    alu_res = a_q << b_q[3:0];
                default: alu_res = 16'h0000;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        rf_d      = rf_q;
        retire    = 1'b0;
        tmo_d     = (req_q && !mem.mem_ack) ? tmo_q + 32'd1 : 32'd0;

        case (state_q)
            S_FETCH: begin
                if (pc_q[0]) begin
                    state_d = S_ERROR;
                end else if (hs) begin
                    ir_d    = mem.mem_rdata;
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    state_d = S_ERROR;
                end
            end
            S_DECODE: begin
                a_d     = rf_q[rs];
                b_d     = rf_q[rt];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op)
                    OP_R: begin
                        if (funct == FN_JR) begin
                            pc_d    = a_q;
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end else if (funct < FN_JR) begin
                            res_d   = alu_res;
                            state_d = S_WB;
                        end else begin
                            state_d = S_ERROR;
                        end
                    end
                    OP_ADDI: begin
                        res_d   = alu_res;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        res_d   = alu_res;
                        state_d = alu_res[0] ? S_ERROR : S_MEM;
                    end
                    OP_BEQ: begin
                        pc_d    = (a_q == b_q) ? pc2 + {sext[14:0], 1'b0} : pc2;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_J, OP_JAL: begin
                        if (op == OP_JAL) begin
                            rf_d[7] = pc2;
                        end
                        pc_d    = {pc2[15:14], ir_q[12:0], 1'b0};
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: begin
                        retire  = 1'b1;
                        state_d = S_HALT;
                    end
                endcase
            end
            S_MEM: begin
                if (hs) begin
                    if (op == OP_SW) begin
                        pc_d    = pc2;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        res_d   = mem.mem_rdata;
                        state_d = S_WB;
                    end
                end else if (tmo_hit) begin
                    state_d = S_ERROR;
                end
            end
            S_WB: begin
                if (dest != 3'd0) begin
                    rf_d[dest] = res_q;
                end
                pc_d    = pc2;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_ERROR;
        endcase

        retired_d = retire ? retired_q + {{(CNT_W-1){1'b0}}, 1'b1} : retired_q;

        // Port outputs are registered from the next state, so a fresh request appears the cycle the state is entered.
        req_d   = ((state_d == S_FETCH) && !pc_d[0]) || (state_d == S_MEM);
        we_d    = (state_d == S_MEM) && (op == OP_SW);
        addr_d  = 16'h0000;
        wdata_d = 16'h0000;
        if (state_d == S_FETCH && !pc_d[0]) begin
            addr_d = pc_d;
        end else if (state_d == S_MEM) begin
            addr_d  = res_d;
            wdata_d = b_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 16'h0000;
            a_q       <= 16'h0000;
            b_q       <= 16'h0000;
            res_q     <= 16'h0000;
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= 16'h0000;
            end
            retired_q <= '0;
            tmo_q     <= 32'd0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            rf_q      <= rf_d;
            retired_q <= retired_d;
            tmo_q     <= tmo_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign pc            = pc_q;
    assign halted        = (state_q == S_HALT);
    assign error         = (state_q == S_ERROR);
    assign instr_retired = retired_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_multi_cycle_core.sv
// Bench for multi_cycle_core: directed programs plus random programs checked against an ISA-level model.
// dut0 runs against a delay-configurable memory; dut1 has a 4-cycle timeout and a memory that never answers.
module tb_multi_cycle_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multi_cycle_core_if m0();
    multi_cycle_core_if m1();

    logic [15:0] pc0, pc1;
    logic        halted0, halted1, error0, error1;
    logic [31:0] ret0, ret1;
    logic [2:0]  st0, st1;

    multi_cycle_core #(.RESET_PC(16'h0000), .TIMEOUT_CYCLES(0), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst), .mem(m0), .pc(pc0), .halted(halted0), .error(error0),
        .instr_retired(ret0), .state_dbg(st0));

    multi_cycle_core #(.RESET_PC(16'h0000), .TIMEOUT_CYCLES(4), .CNT_W(32)) dut1 (
        .clk(clk), .rst(rst), .mem(m1), .pc(pc1), .halted(halted1), .error(error1),
        .instr_retired(ret1), .state_dbg(st1));

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [0:32767];
    logic [15:0] mm  [0:32767];
    int          mem_dly   = 0;
    bit          stray_ack = 1'b0;
    int          hs_cnt    = 0;
    bit          unstable  = 1'b0;

    logic [15:0] e_r [8];
    logic [15:0] e_pc;
    int          e_ret, e_cyc;
    bit          e_halt, e_err;

    function automatic logic [15:0] f_i(input logic [2:0] op, input logic [2:0] rs,
                                        input logic [2:0] rt, input logic [6:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [15:0] f_r(input logic [2:0] rs, input logic [2:0] rt,
                                        input logic [2:0] rd, input logic [3:0] fn);
        return {3'b000, rs, rt, rd, fn};
    endfunction

    function automatic logic [15:0] f_j(input logic [2:0] op, input logic [12:0] ja);
        return {op, ja};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 32768; i++) begin
            mem[i] = 16'h0000;
            mm[i]  = 16'h0000;
        end
    endtask

    task automatic poke(input int idx, input logic [15:0] v);
        mem[idx] = v;
        mm[idx]  = v;
    endtask

    // Memory slave for dut0: answers after mem_dly wait cycles and watches request stability.
    task automatic responder();
        int wcnt = 0;
        bit waiting = 1'b0;
        logic [15:0] pa = 16'h0, pw = 16'h0;
        logic pwe = 1'b0;
        forever begin
            @(negedge clk);
            if (m0.mem_req) begin
                if (waiting && (m0.mem_addr !== pa || m0.mem_wdata !== pw || m0.mem_we !== pwe))
                    unstable = 1'b1;
                pa = m0.mem_addr; pw = m0.mem_wdata; pwe = m0.mem_we;
                if (wcnt >= mem_dly) begin
                    m0.mem_ack   = 1'b1;
                    m0.mem_rdata = mem[m0.mem_addr[15:1]];
                    if (m0.mem_we) mem[m0.mem_addr[15:1]] = m0.mem_wdata;
                    hs_cnt++;
                    wcnt = 0;
                    waiting = 1'b0;
                end else begin
                    m0.mem_ack   = 1'b0;
                    m0.mem_rdata = 16'hDEAD;
                    wcnt++;
                    waiting = 1'b1;
                end
            end else begin
                m0.mem_ack   = stray_ack;
                m0.mem_rdata = 16'hFFFF;
                wcnt = 0;
                waiting = 1'b0;
            end
        end
    endtask

    // Instruction-level interpreter; cycle cost per instruction follows the published latencies.
    task automatic model_run(input int d);
        logic [15:0] r [8];
        logic [15:0] pc, ir, a, b, sx, v, ad;
        int cyc, ret;
        for (int i = 0; i < 8; i++) r[i] = 16'h0;
        pc = 16'h0000; cyc = 1; ret = 0; e_halt = 0; e_err = 0;
        for (int k = 0; k < 2000; k++) begin
            if (pc[0]) begin cyc += 1; e_err = 1; break; end
            ir = mm[pc[15:1]];
            cyc += 3 + d;
            a  = r[ir[12:10]];
            b  = r[ir[9:7]];
            sx = {{9{ir[6]}}, ir[6:0]};
            if (ir[15:13] == 3'd0) begin
                case (ir[3:0])
                    4'd0: v = a + b;
                    4'd1: v = a - b;
                    4'd2: v = a & b;
                    4'd3: v = a | b;
                    4'd4: v = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
                    4'd5: v = a << b[3:0];
                    default: v = 16'd0;
                endcase
                if (ir[3:0] == 4'd6) begin pc = a; ret++; end
                else if (ir[3:0] > 4'd6) begin e_err = 1; break; end
                else begin if (ir[6:4] != 0) r[ir[6:4]] = v; pc += 16'd2; ret++; cyc += 1; end
            end else if (ir[15:13] == 3'd1) begin
                if (ir[9:7] != 0) r[ir[9:7]] = a + sx;
                pc += 16'd2; ret++; cyc += 1;
            end else if (ir[15:13] == 3'd2) begin
                ad = a + sx;
                if (ad[0]) begin e_err = 1; break; end
                cyc += 2 + d;
                if (ir[9:7] != 0) r[ir[9:7]] = mm[ad[15:1]];
                pc += 16'd2; ret++;
            end else if (ir[15:13] == 3'd3) begin
                ad = a + sx;
                if (ad[0]) begin e_err = 1; break; end
                cyc += 1 + d;
                mm[ad[15:1]] = b;
                pc += 16'd2; ret++;
            end else if (ir[15:13] == 3'd4) begin
                pc = (a == b) ? pc + 16'd2 + {sx[14:0], 1'b0} : pc + 16'd2;
                ret++;
            end else if (ir[15:13] == 3'd7) begin
                ret++; e_halt = 1; break;
            end else begin
                v = pc + 16'd2;
                if (ir[15:13] == 3'd6) r[7] = v;
                pc = {v[15:14], ir[12:0], 1'b0};
                ret++;
            end
        end
        e_r = r; e_pc = pc; e_ret = ret; e_cyc = cyc;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        hs_cnt = 0; unstable = 1'b0;
    endtask

    // Counts edges from the reset-release edge until halt/error, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (n < 3000) begin
            @(posedge clk); #1;
            n++;
            if (halted0 || error0) break;
        end
    endtask

    task automatic test_reset();
        clear_mem(); poke(0, 16'hE000); mem_dly = 0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        total++; if (st0 !== 3'd0)         begin bad++; $display("FAIL reset_state got=%0d want=0", st0); end
        total++; if (m0.mem_req !== 1'b0)  begin bad++; $display("FAIL reset_req got=%0b want=0", m0.mem_req); end
        total++; if (pc0 !== 16'h0000)     begin bad++; $display("FAIL reset_pc got=%h want=0000", pc0); end
        total++; if (halted0 !== 1'b0 || error0 !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", halted0, error0); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        total++; if (m0.mem_req !== 1'b1 || m0.mem_addr !== 16'h0000 || m0.mem_we !== 1'b0)
            begin bad++; $display("FAIL first_fetch got req=%b addr=%h we=%b want 1/0000/0", m0.mem_req, m0.mem_addr, m0.mem_we); end
        total++; if (ret0 !== 32'd0 || st0 !== 3'd0 || pc0 !== 16'h0)
            begin bad++; $display("FAIL first_fetch_state got ret=%0d st=%0d pc=%h want 0/0/0000", ret0, st0, pc0); end
    endtask

    task automatic test_alu_program();
        int n;
        clear_mem();
        poke(0, f_i(3'd1, 3'd0, 3'd1, 7'd5));
        poke(1, f_i(3'd1, 3'd0, 3'd2, 7'h7D));
        poke(2, f_r(3'd1, 3'd2, 3'd3, 4'd0));
        poke(3, f_r(3'd2, 3'd1, 3'd4, 4'd4));
        poke(4, 16'hE000);
        mem_dly = 0;
        do_reset(); wait_done(n);
        total++; if (n != 20)                begin bad++; $display("FAIL alu_cycles got=%0d want=20", n); end
        total++; if (dut0.rf_q[3] !== 16'd2) begin bad++; $display("FAIL alu_r3 got=%h want=0002", dut0.rf_q[3]); end
        total++; if (dut0.rf_q[4] !== 16'd1) begin bad++; $display("FAIL alu_slt_r4 got=%h want=0001", dut0.rf_q[4]); end
        total++; if (halted0 !== 1'b1 || ret0 !== 32'd5 || pc0 !== 16'h0008)
            begin bad++; $display("FAIL alu_end got halted=%b ret=%0d pc=%h want 1/5/0008", halted0, ret0, pc0); end
        repeat (4) @(posedge clk); #1;
        total++; if (halted0 !== 1'b1 || ret0 !== 32'd5 || m0.mem_req !== 1'b0)
            begin bad++; $display("FAIL halt_sticky got halted=%b ret=%0d req=%b want 1/5/0", halted0, ret0, m0.mem_req); end
    endtask

    task automatic test_mem_wait();
        int n3, n0;
        clear_mem();
        poke(0, f_i(3'd1, 3'd0, 3'd1, 7'd5));
        poke(1, f_i(3'd1, 3'd0, 3'd6, 7'd32));
        poke(2, f_r(3'd6, 3'd6, 3'd6, 4'd0));
        poke(3, f_i(3'd3, 3'd6, 3'd1, 7'd0));
        poke(4, f_i(3'd2, 3'd6, 3'd5, 7'd0));
        poke(5, 16'hE000);
        mem_dly = 3;
        do_reset(); wait_done(n3);
        total++; if (n3 != 49)                begin bad++; $display("FAIL memwait_cycles got=%0d want=49", n3); end
        total++; if (dut0.rf_q[5] !== 16'd5)  begin bad++; $display("FAIL memwait_lw_r5 got=%h want=0005", dut0.rf_q[5]); end
        total++; if (mem[16'h20] !== 16'd5)   begin bad++; $display("FAIL memwait_sw got=%h want=0005", mem[16'h20]); end
        total++; if (unstable !== 1'b0)       begin bad++; $display("FAIL memwait_stable got=%b want=0", unstable); end
        total++; if (hs_cnt != 8)             begin bad++; $display("FAIL memwait_accesses got=%0d want=8", hs_cnt); end
        mem_dly = 0;
        do_reset(); wait_done(n0);
        total++; if (n3 - n0 != 24)           begin bad++; $display("FAIL memwait_extend got=%0d want=24", n3 - n0); end
    endtask

    task automatic test_control_flow();
        int n;
        mem_dly = 0;
        clear_mem();
        poke(0, f_j(3'd5, 13'd8));
        poke(8, f_i(3'd4, 3'd0, 3'd0, 7'h7E));
        poke(7, 16'hE000);
        do_reset(); wait_done(n);
        total++; if (n != 10 || pc0 !== 16'h000E || ret0 !== 32'd3)
            begin bad++; $display("FAIL beq_back got cyc=%0d pc=%h ret=%0d want 10/000e/3", n, pc0, ret0); end
        clear_mem();
        poke(0, f_j(3'd5, 13'h10));
        poke(16'h10, f_j(3'd6, 13'h100));
        poke(16'h100, 16'hE000);
        do_reset(); wait_done(n);
        total++; if (pc0 !== 16'h0200 || dut0.rf_q[7] !== 16'h0022)
            begin bad++; $display("FAIL jal got pc=%h r7=%h want 0200/0022", pc0, dut0.rf_q[7]); end
        poke(16'h100, f_r(3'd7, 3'd0, 3'd0, 4'd6));
        poke(16'h11, 16'hE000);
        do_reset(); wait_done(n);
        total++; if (n != 13 || pc0 !== 16'h0022 || ret0 !== 32'd4)
            begin bad++; $display("FAIL jr got cyc=%0d pc=%h ret=%0d want 13/0022/4", n, pc0, ret0); end
    endtask

    task automatic test_errors();
        int n;
        mem_dly = 0;
        clear_mem();
        poke(0, f_i(3'd1, 3'd0, 3'd1, 7'd32));
        poke(1, f_r(3'd1, 3'd1, 3'd1, 4'd0));
        poke(2, f_i(3'd2, 3'd1, 3'd2, 7'd1));
        poke(3, 16'hE000);
        do_reset(); wait_done(n);
        total++; if (n != 12 || error0 !== 1'b1 || halted0 !== 1'b0)
            begin bad++; $display("FAIL misalign_lw got cyc=%0d err=%b halt=%b want 12/1/0", n, error0, halted0); end
        total++; if (hs_cnt != 3 || ret0 !== 32'd2)
            begin bad++; $display("FAIL misalign_noreq got acc=%0d ret=%0d want 3/2", hs_cnt, ret0); end
        repeat (5) @(posedge clk); #1;
        total++; if (error0 !== 1'b1 || st0 !== 3'd6 || m0.mem_req !== 1'b0 || ret0 !== 32'd2)
            begin bad++; $display("FAIL error_sticky got err=%b st=%0d req=%b ret=%0d want 1/6/0/2", error0, st0, m0.mem_req, ret0); end
        clear_mem();
        poke(0, f_r(3'd1, 3'd2, 3'd3, 4'hF));
        do_reset(); wait_done(n);
        total++; if (n != 4 || error0 !== 1'b1 || ret0 !== 32'd0)
            begin bad++; $display("FAIL bad_funct got cyc=%0d err=%b ret=%0d want 4/1/0", n, error0, ret0); end
        clear_mem();
        poke(0, f_i(3'd1, 3'd0, 3'd1, 7'd3));
        poke(1, f_r(3'd1, 3'd0, 3'd0, 4'd6));
        do_reset(); wait_done(n);
        total++; if (n != 9 || error0 !== 1'b1 || pc0 !== 16'h0003 || hs_cnt != 2)
            begin bad++; $display("FAIL odd_pc got cyc=%0d err=%b pc=%h acc=%0d want 9/1/0003/2", n, error0, pc0, hs_cnt); end
    endtask

    task automatic test_timeout();
        clear_mem(); poke(0, 16'hE000); mem_dly = 0;
        do_reset();
        @(posedge clk); #1;
        total++; if (m1.mem_req !== 1'b1) begin bad++; $display("FAIL tmo_req got=%b want=1", m1.mem_req); end
        repeat (3) @(posedge clk); #1;
        total++; if (error1 !== 1'b0 || m1.mem_req !== 1'b1)
            begin bad++; $display("FAIL tmo_early got err=%b req=%b want 0/1", error1, m1.mem_req); end
        @(posedge clk); #1;
        total++; if (error1 !== 1'b1 || m1.mem_req !== 1'b0 || st1 !== 3'd6)
            begin bad++; $display("FAIL tmo_fire got err=%b req=%b st=%0d want 1/0/6", error1, m1.mem_req, st1); end
        repeat (3) @(posedge clk); #1;
        total++; if (error1 !== 1'b1 || ret1 !== 32'd0)
            begin bad++; $display("FAIL tmo_sticky got err=%b ret=%0d want 1/0", error1, ret1); end
    endtask

    task automatic test_reset_midop();
        int n;
        bit reached = 1'b0;
        clear_mem();
        poke(0, f_i(3'd1, 3'd0, 3'd1, 7'd5));
        poke(1, f_i(3'd3, 3'd0, 3'd1, 7'h7E));
        poke(2, 16'hE000);
        mem_dly = 6;
        do_reset();
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (st0 == 3'd3 && m0.mem_req) begin reached = 1'b1; break; end
        end
        total++; if (!reached) begin bad++; $display("FAIL midop_reach got=0 want=1"); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        total++; if (m0.mem_req !== 1'b0 || pc0 !== 16'h0 || ret0 !== 32'd0 || st0 !== 3'd0)
            begin bad++; $display("FAIL midop_reset got req=%b pc=%h ret=%0d st=%0d want 0/0000/0/0", m0.mem_req, pc0, ret0, st0); end
        for (int i = 1; i < 8; i++) begin
            total++; if (dut0.rf_q[i] !== 16'h0) begin bad++; $display("FAIL midop_reg%0d got=%h want=0000", i, dut0.rf_q[i]); end
        end
        total++; if (mem[16'h7FFF] !== 16'h0) begin bad++; $display("FAIL midop_nostore got=%h want=0000", mem[16'h7FFF]); end
        stray_ack = 1'b1; mem_dly = 0;
        @(negedge clk); rst = 1'b0;
        wait_done(n);
        stray_ack = 1'b0;
        total++; if (n != 12 || halted0 !== 1'b1 || ret0 !== 32'd3)
            begin bad++; $display("FAIL midop_rerun got cyc=%0d halt=%b ret=%0d want 12/1/3", n, halted0, ret0); end
        total++; if (mem[16'h7FFF] !== 16'd5) begin bad++; $display("FAIL midop_store got=%h want=0005", mem[16'h7FFF]); end
    endtask

    task automatic test_random();
        int n, ni, d;
        logic [2:0] a, b, c;
        for (int it = 0; it < 20; it++) begin
            clear_mem();
            ni = int'($urandom_range(4, 12));
            for (int k = 0; k < ni; k++) begin
                a = 3'($urandom_range(0, 7)); b = 3'($urandom_range(0, 7)); c = 3'($urandom_range(0, 7));
                case ($urandom_range(0, 3))
                    0: poke(k, f_i(3'd1, a, b, 7'($urandom_range(0, 127))));
                    1: poke(k, f_r(a, b, c, 4'($urandom_range(0, 5))));
                    2: poke(k, f_i(3'd3, 3'd0, b, 7'(128 - 2 * $urandom_range(1, 32))));
                    default: poke(k, f_i(3'd2, 3'd0, b, 7'(128 - 2 * $urandom_range(1, 32))));
                endcase
            end
            poke(ni, 16'hE000);
            d = int'($urandom_range(0, 2));
            mem_dly = d;
            model_run(d);
            do_reset(); wait_done(n);
            total++; if (n != e_cyc) begin bad++; $display("FAIL rnd%0d_cycles got=%0d want=%0d", it, n, e_cyc); end
            total++; if (halted0 !== e_halt || error0 !== e_err || pc0 !== e_pc || ret0 !== 32'(e_ret))
                begin bad++; $display("FAIL rnd%0d_end got h=%b e=%b pc=%h ret=%0d want %b/%b/%h/%0d", it, halted0, error0, pc0, ret0, e_halt, e_err, e_pc, e_ret); end
            for (int i = 1; i < 8; i++) begin
                total++; if (dut0.rf_q[i] !== e_r[i]) begin bad++; $display("FAIL rnd%0d_r%0d got=%h want=%h", it, i, dut0.rf_q[i], e_r[i]); end
            end
        end
    endtask

    initial begin
        m0.mem_ack = 1'b0; m0.mem_rdata = 16'h0;
        m1.mem_ack = 1'b0; m1.mem_rdata = 16'h0;
        clear_mem();
        fork
            responder();
        join_none
        test_reset();
        test_alu_program();
        test_mem_wait();
        test_control_flow();
        test_errors();
        test_timeout();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
